bf2i_sdf_stage: RTL

BF2I_SDF_STAGE -- requirements
Module: bf2i_sdf_stage

---
 rtl/bf2i_sdf_stage_pkg.sv | 29 ++
 rtl/bf2i_sdf_stage_delay_line.sv | 20 ++
 rtl/bf2i_sdf_stage.sv | 59 +++++
 3 files changed

// File: rtl/bf2i_sdf_stage_pkg.sv
// R22SdfDefines: complex sample type and scaled add/sub; R22SDF_ROUND_EN selects round-half-up when halving.
package R22SdfDefines;
    localparam int W = 16;
    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } Cplx_t;
`ifdef R22SDF_ROUND_EN
    localparam logic signed [W+1:0] RND = 1;
`else
    localparam logic signed [W+1:0] RND = 0;
`endif
    // Two guard bits keep the rounding increment from overflowing before the shift.
    function automatic logic signed [W-1:0] scl(input logic signed [W+1:0] v, input logic scale);
        return scale ? W'((v + RND) >>> 1) : W'(v);
    endfunction
    function automatic Cplx_t cadd(input Cplx_t a, input Cplx_t b, input logic scale);
        Cplx_t c;
        c.re = scl((W+2)'(a.re) + (W+2)'(b.re), scale);
        c.im = scl((W+2)'(a.im) + (W+2)'(b.im), scale);
        return c;
    endfunction
    function automatic Cplx_t csub(input Cplx_t a, input Cplx_t b, input logic scale);
        Cplx_t c;
        c.re = scl((W+2)'(a.re) - (W+2)'(b.re), scale);
        c.im = scl((W+2)'(a.im) - (W+2)'(b.im), scale);
        return c;
    endfunction
endpackage

// File: rtl/bf2i_sdf_stage_delay_line.sv
// sdf_delay_line: DEPTH-sample shift register advancing only when enabled; contents are never reset.
module sdf_delay_line
    import R22SdfDefines::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  en_i,
    input  Cplx_t d_i,
    output Cplx_t d_o
);
    Cplx_t mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end
    assign d_o = mem_q[DEPTH-1];
endmodule

// File: rtl/bf2i_sdf_stage.sv
// bf2i_sdf_stage: radix-2^2 SDF Bf2I butterfly with feedback delay; R22SDF_ROUND_EN enables rounding when scaled.
module bf2i_sdf_stage
    import R22SdfDefines::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  Cplx_t x,
    input  logic  scale,
    output logic  out_valid,
    output Cplx_t z,
    output logic  s_o,
    output logic  t_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, prime_q, prime_d;
    logic s, primed, emit, ov_q, s_q, s_d, t_q, t_d;
    Cplx_t d, fb, res, z_q, z_d;
    sdf_delay_line #(.DEPTH(DEPTH)) u_dl (.clk(clk), .en_i(in_valid), .d_i(fb), .d_o(d));
    // Priming saturates at DEPTH, which is exactly when its MSB sets.
    assign s = in_cnt_q[CW-1];
    assign primed = prime_q[CW-1];
    always_comb begin
        fb = s ? csub(d, x, scale) : x;
        res = s ? cadd(d, x, scale) : d;
        emit = in_valid && primed;
        in_cnt_d = in_valid ? in_cnt_q + CW'(1) : in_cnt_q;
        prime_d = (in_valid && !primed) ? prime_q + CW'(1) : prime_q;
        out_cnt_d = emit ? out_cnt_q + CW'(1) : out_cnt_q;
        z_d = emit ? res : z_q;
        s_d = emit ? out_cnt_q[CW-2] : s_q;
        t_d = emit ? ~out_cnt_q[CW-1] : t_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q <= '0;
            out_cnt_q <= '0;
            prime_q <= '0;
            ov_q <= 1'b0;
            z_q <= '0;
            s_q <= 1'b0;
            t_q <= 1'b1;
        end else begin
            in_cnt_q <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            prime_q <= prime_d;
            ov_q <= emit;
            z_q <= z_d;
            s_q <= s_d;
            t_q <= t_d;
        end
    end
    assign out_valid = ov_q;
    assign z = z_q;
    assign s_o = s_q;
    assign t_o = t_q;
endmodule
